// File: rtl/meter_display.sv
// Parking-meter display back-end: iterative double-dabble BCD conversion, 4-digit
// multiplexed common-anode drive and blink gating. Optional build macro: METER_BLANK_LEADING_EN.
module meter_display #(
  parameter int SCAN_DIV = 100000,
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] val,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [13:0]        val_sat;
  logic [13:0]        cap;
  logic [13:0]        bin;
  logic [15:0]        bcd;
  logic [15:0]        bcd_adj;
  logic [3:0]         iter;
  logic [15:0]        dig;
  logic [13:0]        shown_val;
  logic               shown;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [TICK_W-1:0]  tick_cnt;
  logic [1:0]         phase;
  logic [3:0]         nibble;
  logic               lit;
  logic               digit_on;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign val_sat = (val > 14'd9999) ? 14'd9999 : val;

  // Converter FSM: state register plus next-state logic.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap       <= '0;
      bin       <= '0;
      bcd       <= '0;
      iter      <= '0;
      dig       <= '0;
      shown_val <= '0;
      shown     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cap  <= val_sat;
          bin  <= val_sat;
          bcd  <= '0;
          iter <= '0;
        end
        SHIFT: begin
          bcd  <= {bcd_adj[14:0], bin[13]};
          bin  <= {bin[12:0], 1'b0};
          iter <= iter + 4'd1;
        end
        DONE: begin
          dig       <= bcd;
          shown_val <= cap;
          shown     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit scan and blink tick run freely and independently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      tick_cnt <= '0;
      phase    <= '0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        phase    <= phase + 2'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign nibble = dig[{idx, 2'b00} +: 4];

  always_comb begin
    if (shown_val == 14'd0)        lit = ~phase[0];
    else if (shown_val <= 14'd199) lit = ~phase[1];
    else                           lit = 1'b1;
  end

`ifdef METER_BLANK_LEADING_EN
  // A slot is blank when it and every more significant digit are zero.
  always_comb begin
    case (idx)
      2'd3:    digit_on = (dig[15:12] != 4'd0);
      2'd2:    digit_on = (dig[15:8] != 8'd0);
      2'd1:    digit_on = (dig[15:4] != 12'd0);
      default: digit_on = 1'b1;
    endcase
  end
`else
  assign digit_on = 1'b1;
`endif

  // Outputs stay dark until the first conversion has been published.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      dp  <= 1'b1;
      seg <= shown ? seg_decode(nibble) : 7'b1111111;
      an  <= (shown && lit && digit_on) ? ~(4'b0001 << idx) : 4'b1111;
    end
  end

endmodule

// File: tb/tb_meter_display.sv
// Self-checking bench for meter_display: directed timing checks plus randomized
// display windows scored against an arithmetic reference model.
module tb_meter_display;
  localparam int SCAN_DIV = 4;
  localparam int TICK_DIV = 20;
  localparam int WIN      = 160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] val = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int win_done = 0;
  logic [13:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  meter_display #(.SCAN_DIV(SCAN_DIV), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .val(val), .an(an), .seg(seg), .dp(dp)
  );

  // reference model
  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: ref_seg = 7'b1000000;
      1: ref_seg = 7'b1111001;
      2: ref_seg = 7'b0100100;
      3: ref_seg = 7'b0110000;
      4: ref_seg = 7'b0011001;
      5: ref_seg = 7'b0010010;
      6: ref_seg = 7'b0000010;
      7: ref_seg = 7'b1111000;
      8: ref_seg = 7'b0000000;
      9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b1111111;
    endcase
  endfunction

  function automatic int ref_digit(input int v, input int pos);
    int p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic int ref_slots(input int v);
`ifdef METER_BLANK_LEADING_EN
    if (v >= 1000) return 4;
    if (v >= 100)  return 3;
    if (v >= 10)   return 2;
    return 1;
`else
    return (v >= 0) ? 4 : 0;
`endif
  endfunction

  function automatic int ref_mode(input int v);
    if (v == 0)   return 0;
    if (v <= 199) return 1;
    return 2;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_cyc: cycle %0d never reached, at %0d", n, cyc);
    end
  endtask

  task automatic do_reset(input logic [13:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    val   = v;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_blank_until_first_pass();
    for (int n = 1; n <= 15; n++) begin
      wait_cyc(n);
      check("blank_an", int'(an), 'b1111);
      check("blank_seg", int'(seg), 'b1111111);
    end
  endtask

  task automatic apply(input logic [13:0] v);
    int target;
    int guard = 0;
    val = v;
    repeat (40) @(negedge clk);
    target = win_done + 1;
    exp_q.push_back((v > 14'd9999) ? 14'd9999 : v);
    while (win_done < target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (win_done < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL window_timeout: value %0d not scored", v);
    end
  endtask

  // scoreboard monitor: observes one full blink period pair per expected value
  task automatic run_window(input int v);
    int lit = 0;
    int run = 0;
    int maxrun = 0;
    int k = ref_slots(v);
    int mode = ref_mode(v);
    int slot;
    logic [3:0] pat;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      if (c == 0) check("dp_off", int'(dp), 1);
      if (an == 4'b1111) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
        lit++;
        slot = -1;
        for (int i = 0; i < 4; i++) begin
          pat = ~(4'b0001 << i);
          if (an == pat) slot = i;
        end
        if (slot < 0) begin
          check("an_onehot", int'(an), 'b1110);
        end else begin
          check("slot_shown", (slot < k) ? 1 : 0, 1);
          check("seg_digit", int'(seg), int'(ref_seg(ref_digit(v, slot))));
        end
      end
    end
    if (k == 4 || mode == 2) check("lit_count", lit, (mode == 2) ? 40 * k : 80);
    if (k == 4) check("max_dark_run", maxrun, (mode == 0) ? 20 : (mode == 1) ? 40 : 0);
  endtask

  initial begin
    logic [13:0] v;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        run_window(int'(v));
        win_done++;
      end
    end
  end

  initial begin
    #1000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // stimulus
  initial begin
    int r;
    logic [13:0] rv;
    rst_n = 1'b0;
    val   = '0;
    repeat (3) @(negedge clk);
    check("rst_an", int'(an), 'b1111);
    check("rst_seg", int'(seg), 'b1111111);
    check("rst_dp", int'(dp), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check_blank_until_first_pass();
    wait_cyc(18);
    check("first_lit_an", int'(an), 'b1110);
    check("first_lit_seg", int'(seg), 'b1000000);
    wait_cyc(22);
    check("zero_blink_off", int'(an), 'b1111);
    wait_cyc(49);
    check("zero_blink_on", int'(an), 'b1110);

    apply(14'd1234);
    apply(14'd150);
    apply(14'd200);
    apply(14'h3FFF);
    apply(14'd0);

    // value changed mid-conversion: first pass keeps the old value
    do_reset(14'd300);
    wait_cyc(5);
    val = 14'd100;
    wait_cyc(17);
    check("old_ones_an", int'(an), 'b1110);
    check("old_ones_seg", int'(seg), 'b1000000);
    wait_cyc(25);
    check("old_hund_an", int'(an), 'b1011);
    check("old_hund_seg", int'(seg), 'b0110000);
    wait_cyc(42);
    check("new_mode_dark", int'(an), 'b1111);
    apply(14'd100);

    // reset in the middle of converting 5678
    do_reset(14'd5678);
    wait_cyc(8);
    rst_n = 1'b0;
    val   = 14'd5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_blank_until_first_pass();
    wait_cyc(17);
    check("abort_ones_an", int'(an), 'b1110);
    check("abort_ones_seg", int'(seg), 'b0010010);
    apply(14'd5);

    repeat (8) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       rv = 14'd0;
        1:       rv = 14'($urandom_range(1, 199));
        2:       rv = 14'($urandom_range(200, 9999));
        default: rv = 14'($urandom_range(10000, 16383));
      endcase
      apply(rv);
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
